alarm_ctrl: RTL and testbench
=============================

# alarm_ctrl

Lights-on/door-open reminder alarm controller: the device that the alarm bench drives. Samples the light (sLuz), door (sPrta) and ignition (sIgn) sense lines and drives the alarm line (sAlr). The alarm sounds as a pulsed chime once the lights are on, the door is open and the ignition is off continuously for a programmable delay.

## Interface
Parameters:
- DELAY, 4: cycles the alarm condition must hold before the chime starts (≥1).
- ON_CYC, 2: cycles sAlr is high per chime pulse (≥1).
- OFF_CYC, 2: cycles sAlr is low between pulses (≥1).
- MAX_BEEPS, 8: number of pulses before auto-mute (used only with ALARM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; one clock domain, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sLuz  in  1  lights on (asynchronous to clk).
- sPrta  in  1  door open (asynchronous to clk).
- sIgn  in  1  ignition on (asynchronous to clk).
- sAlr  out  1  alarm/chime drive, registered.

## Operation
- Each input passes through a 2-flop synchronizer. cond = luz_s & prta_s & ~ign_s.
- FSM states: IDLE, WAIT, SOUND, MUTE.
- IDLE: sAlr=0. If cond → WAIT, with the delay counter cleared.
- WAIT: sAlr=0. If !cond → IDLE. Otherwise the counter increments. When the counter reaches DELAY-1 with cond still true → SOUND, with sAlr=1 and the phase counter cleared.
- SOUND: sAlr is high for ON_CYC cycles, then low for OFF_CYC cycles, and repeats. The phase counter reloads at each on/off boundary. The beep counter increments at each ON→OFF transition.
- SOUND exit: if !cond → IDLE, with sAlr=0 on the same edge. This takes priority over phase and beep events.
- MUTE: only reachable with ALARM_TIMEOUT_EN. sAlr=0. Stays in MUTE while cond holds; !cond → IDLE.
- Any exit to IDLE clears the delay, phase and beep counters. A fresh cond restarts the full DELAY.
- Counters are sized with $clog2 of their parameter. The beep counter saturates at MAX_BEEPS and never wraps.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, sAlr=0.
  - All synchronizer flops and counters cleared.
  - Reset mid-SOUND drops sAlr to 0 without waiting for a clock edge.
- Assertion latency: cond inputs change before edge t → luz_s/prta_s/ign_s valid after edge t+1 → WAIT at edge t+2 → SOUND and sAlr=1 at edge t+2+DELAY. With default DELAY=4 this is edge t+6.
- Deassertion latency: any input leaves the condition before edge t → sAlr=0 and state=IDLE at edge t+2.
- Pulse shape: sAlr is exactly ON_CYC cycles high and OFF_CYC cycles low, so the period is ON_CYC+OFF_CYC.
- Glitch of one cycle or less on an input during WAIT: returns to IDLE and the delay restarts. There is no hysteresis.
- If the ignition turns on during SOUND, the alarm is silenced within 2 cycles. It does not finish the current pulse.

## Configuration
- ALARM_TIMEOUT_EN defined:
  - After the MAX_BEEPS-th pulse ends (its ON→OFF edge), the FSM goes SOUND → MUTE with sAlr=0.
  - The alarm stays silent until cond clears, then returns to IDLE.
- Not defined:
  - MUTE state and beep counter are not compiled.
  - SOUND chimes indefinitely while cond holds.

## Structure
- Package alarm_pkg holds:
  - the state enum type (IDLE, WAIT, SOUND, MUTE; 2 bits);
  - default parameter constants;
  - a counter-width helper constant.
- Sub-module sync_2ff: a 2-flop synchronizer with asynchronous active-low reset, width parameter, reset value 0. Instantiated once with width 3 for sLuz/sPrta/sIgn.
- alarm_ctrl contains the FSM, the delay counter, the phase counter and the beep counter.

## Test plan
- Reset: hold rst_n=0 with all inputs at 1. sAlr=0 and state=IDLE. Assert rst_n=0 during SOUND → sAlr=0 immediately.
- Basic alarm (defaults): sLuz=1, sPrta=1, sIgn=0 before edge 0 → sAlr first high at edge 6. Pattern is 2 high, 2 low, repeating.
- Ignition blocks: sLuz=1, sPrta=1, sIgn=1 held for 50 cycles → sAlr stays 0 and state never leaves IDLE.
- Early release: condition held for 3 cycles then sPrta=0 → sAlr never rises. Reapplying the condition takes the full 6 edges to reach sAlr=1.
- Silence: sAlr pulsing, then sLuz=0 before edge t → sAlr=0 at edge t+2 and state=IDLE.
- Timeout (ALARM_TIMEOUT_EN, MAX_BEEPS=8):
  - Condition held for 100 cycles → exactly 8 pulses, then MUTE with sAlr=0.
  - Dropping sPrta returns to IDLE.
  - Reapplying the condition starts a new 8-pulse sequence.
  - Without the macro the same stimulus gives 23 or more pulses.

Source files
------------

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types, default parameters and width helper for alarm_ctrl
//
// Contents:
//   state_e        - controller state encoding (IDLE, WAIT, SOUND, MUTE), 2 bits
//   DEF_*          - default values for the alarm_ctrl parameters
//   cnt_w()        - bit width of a counter that must hold values 0..n-1 (minimum 1)
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SOUND = 2'd2,
        MUTE  = 2'd3
    } state_e;

    localparam int DEF_DELAY     = 4;
    localparam int DEF_ON_CYC    = 2;
    localparam int DEF_OFF_CYC   = 2;
    localparam int DEF_MAX_BEEPS = 8;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, async active-low reset, resets to 0
//
// Ports:
//   clk    in          destination clock
//   rst_n  in          asynchronous active-low reset
//   d      in  [W-1:0] asynchronous inputs
//   q      out [W-1:0] synchronized outputs (two clk edges of latency)
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - lights-on/door-open reminder chime controller
//
// Optional feature macro: ALARM_TIMEOUT_EN (auto-mute after MAX_BEEPS pulses).
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   sLuz   in   lights on   (asynchronous)
//   sPrta  in   door open   (asynchronous)
//   sIgn   in   ignition on (asynchronous)
//   sAlr   out  registered chime drive
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int DELAY     = DEF_DELAY,
    parameter int ON_CYC    = DEF_ON_CYC,
    parameter int OFF_CYC   = DEF_OFF_CYC,
    parameter int MAX_BEEPS = DEF_MAX_BEEPS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sLuz,
    input  logic sPrta,
    input  logic sIgn,
    output logic sAlr
);

    localparam int PH_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int DW     = cnt_w(DELAY);
    localparam int PW     = cnt_w(PH_MAX);

    localparam logic [DW-1:0] DLY_LAST = DW'(DELAY - 1);
    localparam logic [PW-1:0] ON_LAST  = PW'(ON_CYC - 1);
    localparam logic [PW-1:0] OFF_LAST = PW'(OFF_CYC - 1);

    if (DELAY < 1 || ON_CYC < 1 || OFF_CYC < 1 || MAX_BEEPS < 1) begin : g_bad_param
        $error("alarm_ctrl: DELAY, ON_CYC, OFF_CYC and MAX_BEEPS must all be >= 1");
    end

    logic [2:0] sync_out;
    logic       luz_s, prta_s, ign_s, cond;

    sync_2ff #(.WIDTH(3)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({sLuz, sPrta, sIgn}),
        .q     (sync_out)
    );

    assign {luz_s, prta_s, ign_s} = sync_out;
    assign cond = luz_s & prta_s & ~ign_s;

    state_e        state_q, state_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [PW-1:0] ph_q, ph_d;
    logic          alr_q, alr_d;

`ifdef ALARM_TIMEOUT_EN
    localparam int BW = cnt_w(MAX_BEEPS + 1);
    localparam logic [BW-1:0] BEEP_MAX  = BW'(MAX_BEEPS);
    localparam logic [BW-1:0] BEEP_LAST = BW'(MAX_BEEPS - 1);
    logic [BW-1:0] beep_q, beep_d;
`endif

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        ph_d    = ph_q;
        alr_d   = alr_q;
`ifdef ALARM_TIMEOUT_EN
        beep_d  = beep_q;
`endif

        case (state_q)
            IDLE: begin
                alr_d = 1'b0;
                if (cond) begin
                    state_d = WAIT;
                    dly_d   = '0;
                end
            end

            WAIT: begin
                alr_d = 1'b0;
                if (!cond) begin
                    state_d = IDLE;
                    dly_d   = '0;
                end else if (dly_q == DLY_LAST) begin
                    state_d = SOUND;
                    alr_d   = 1'b1;
                    ph_d    = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end

            SOUND: begin
                // Losing the condition silences at once, even mid-pulse.
                if (!cond) begin
                    state_d = IDLE;
                    alr_d   = 1'b0;
                    dly_d   = '0;
                    ph_d    = '0;
`ifdef ALARM_TIMEOUT_EN
                    beep_d  = '0;
`endif
                end else if (alr_q) begin
                    if (ph_q == ON_LAST) begin
                        alr_d = 1'b0;
                        ph_d  = '0;
`ifdef ALARM_TIMEOUT_EN
                        if (beep_q != BEEP_MAX) begin
                            beep_d = beep_q + 1'b1;
                        end
                        if (beep_q == BEEP_LAST) begin
                            state_d = MUTE;
                        end
`endif
                    end else begin
                        ph_d = ph_q + 1'b1;
                    end
                end else begin
                    if (ph_q == OFF_LAST) begin
                        alr_d = 1'b1;
                        ph_d  = '0;
                    end else begin
                        ph_d = ph_q + 1'b1;
                    end
                end
            end

`ifdef ALARM_TIMEOUT_EN
            MUTE: begin
                alr_d = 1'b0;
                if (!cond) begin
                    state_d = IDLE;
                    dly_d   = '0;
                    ph_d    = '0;
                    beep_d  = '0;
                end
            end
`endif

            default: begin
                state_d = IDLE;
                alr_d   = 1'b0;
                dly_d   = '0;
                ph_d    = '0;
`ifdef ALARM_TIMEOUT_EN
                beep_d  = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dly_q   <= '0;
            ph_q    <= '0;
            alr_q   <= 1'b0;
`ifdef ALARM_TIMEOUT_EN
            beep_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            ph_q    <= ph_d;
            alr_q   <= alr_d;
`ifdef ALARM_TIMEOUT_EN
            beep_q  <= beep_d;
`endif
        end
    end

    assign sAlr = alr_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - self-checking bench for alarm_ctrl (directed + random vs. behavioural model)
module tb_alarm_ctrl;

    localparam int DELAY     = 4;
    localparam int ON_CYC    = 2;
    localparam int OFF_CYC   = 2;
    localparam int MAX_BEEPS = 8;
    localparam int PER       = ON_CYC + OFF_CYC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sLuz  = 1'b1;
    logic sPrta = 1'b1;
    logic sIgn  = 1'b1;
    logic sAlr;

    int tests = 0;
    int fails = 0;

    alarm_ctrl #(
        .DELAY     (DELAY),
        .ON_CYC    (ON_CYC),
        .OFF_CYC   (OFF_CYC),
        .MAX_BEEPS (MAX_BEEPS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sLuz  (sLuz),
        .sPrta (sPrta),
        .sIgn  (sIgn),
        .sAlr  (sAlr)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: sAlr=%0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cnt(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference: the chime depends only on how many consecutive edges the
    // synchronized condition has been true (run). Synchronized value seen at
    // edge n is the raw condition applied before edge n-2.
    logic m_d1 = 1'b0, m_d2 = 1'b0, m_cs = 1'b0, m_exp = 1'b0;
    int   m_run = 0;

    function automatic logic model_out(input int run);
        int k;
        k = run - (DELAY + 1);
        if (k < 0) return 1'b0;
`ifdef ALARM_TIMEOUT_EN
        if (k / PER >= MAX_BEEPS) return 1'b0;
`endif
        return (k % PER) < ON_CYC;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_d1 = 1'b0; m_d2 = 1'b0; m_run = 0; m_exp = 1'b0;
        end else begin
            m_cs  = m_d2;
            m_d2  = m_d1;
            m_d1  = sLuz & sPrta & ~sIgn;
            m_run = m_cs ? ((m_run < 100000) ? m_run + 1 : m_run) : 0;
            m_exp = m_cs & model_out(m_run);
        end
        #1;
        check_bit("model", sAlr, m_exp);
    end

    int   highs, first, pulses;
    logic prev;
    logic [0:15] pat;
    int   r;

    task automatic count_pulses(input int n, output int cnt);
        logic p;
        p   = sAlr;
        cnt = 0;
        repeat (n) begin
            @(posedge clk); #2;
            if (sAlr && !p) cnt++;
            p = sAlr;
        end
    endtask

    initial begin
        // Reset held with every input high
        repeat (3) @(posedge clk);
        #2 check_bit("reset_hold", sAlr, 1'b0);

        // Basic alarm: condition applied before edge 0
        @(negedge clk);
        rst_n = 1'b1;
        sIgn  = 1'b0;
        pat   = 16'b0000001100110011;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #2;
            check_bit($sformatf("basic_edge%0d", i), sAlr, pat[i]);
        end

        // Async reset while sAlr is high
        #1 rst_n = 1'b0;
        #1 check_bit("reset_async", sAlr, 1'b0);
        sIgn = 1'b1;
        @(negedge clk) rst_n = 1'b1;

        // Ignition on blocks the alarm
        highs = 0;
        repeat (50) begin
            @(posedge clk); #2;
            highs += int'(sAlr);
        end
        check_cnt("ign_block", highs, 0, 0);

        // Early release after 3 cycles
        @(negedge clk) sIgn = 1'b0;
        repeat (3) @(negedge clk);
        sPrta = 1'b0;
        highs = 0;
        repeat (12) begin
            @(posedge clk); #2;
            highs += int'(sAlr);
        end
        check_cnt("early_release", highs, 0, 0);

        // Reapply: full latency again
        @(negedge clk) sPrta = 1'b1;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (sAlr && first < 0) first = i;
        end
        check_cnt("restart_latency", first, 6, 6);

        // Silence: lights off before edge t -> low at t+2 and stays low
        @(negedge clk) sLuz = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        check_bit("silence_t2", sAlr, 1'b0);
        highs = 0;
        repeat (10) begin
            @(posedge clk); #2;
            highs += int'(sAlr);
        end
        check_cnt("silence_hold", highs, 0, 0);

        // Long hold: timeout vs. endless chime
        @(negedge clk) sLuz = 1'b1;
        count_pulses(100, pulses);
`ifdef ALARM_TIMEOUT_EN
        check_cnt("pulses_run1", pulses, MAX_BEEPS, MAX_BEEPS);
`else
        check_cnt("pulses_run1", pulses, 23, 1000);
`endif
        @(negedge clk) sPrta = 1'b0;
        repeat (6) @(posedge clk);
        #2 check_bit("drop_idle", sAlr, 1'b0);
        @(negedge clk) sPrta = 1'b1;
        count_pulses(100, pulses);
`ifdef ALARM_TIMEOUT_EN
        check_cnt("pulses_run2", pulses, MAX_BEEPS, MAX_BEEPS);
`else
        check_cnt("pulses_run2", pulses, 23, 1000);
`endif

        // Random phase: sticky condition with glitches and rare resets
        repeat (3000) begin
            @(negedge clk);
            rst_n = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                r = int'($urandom_range(0, 3));
                if (r != 0) begin
                    sLuz = 1'b1; sPrta = 1'b1; sIgn = 1'b0;
                end else begin
                    sLuz  = 1'($urandom_range(0, 1));
                    sPrta = 1'($urandom_range(0, 1));
                    sIgn  = 1'($urandom_range(0, 1));
                end
            end
            if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #3;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
